// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and helpers for the fetch PC sequencer.
package fetch_pc_ctrl_pkg;

    localparam int XLEN = 32;

    // Request sequencing: FETCH issues, WAIT expects a live response,
    // DRAIN swallows a response that a redirect has made stale.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Contents of the single output slot presented to decode.
    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
    } fetch_packet_t;

    // Instructions are 4-byte aligned; low address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    // The I-cache is addressed in 8-byte lines.
    function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select of the next fetch PC: EX redirect, then ROB redirect,
// then branch prediction, then sequential advance, else hold.
module fetch_redirect_mux
    import fetch_pc_ctrl_pkg::*;
(
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_pc,
    input  logic            rob_redirect_valid,
    input  logic [XLEN-1:0] rob_redirect_pc,
    input  logic            bp_take,
    input  logic [XLEN-1:0] bp_redirect_pc,
    input  logic            seq_advance,
    input  logic [XLEN-1:0] cur_pc,
    output logic            flush,
    output logic            bp_sel,
    output logic [XLEN-1:0] next_pc
);

    // A flush from either recovery source overrides any prediction.
    always_comb begin
        flush   = ex_redirect_valid | rob_redirect_valid;
        bp_sel  = bp_take & ~flush;
        next_pc = cur_pc;
        if (ex_redirect_valid) begin
            next_pc = word_align(ex_redirect_pc);
        end else if (rob_redirect_valid) begin
            next_pc = word_align(rob_redirect_pc);
        end else if (bp_take) begin
            next_pc = word_align(bp_redirect_pc);
        end else if (seq_advance) begin
            next_pc = cur_pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC owner: issues one line request at a time to the I-cache,
// drops responses made stale by redirects, and presents one instruction
// per handshake to decode through a registered slot.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_pc,
    input  logic            rob_redirect_valid,
    input  logic [XLEN-1:0] rob_redirect_pc,
    input  logic            bp_redirect_valid,
    input  logic [XLEN-1:0] bp_redirect_pc,
    input  logic            fetch_stall,
    input  logic            icache_req_ready,
    output logic            icache_req_valid,
    output logic [XLEN-1:0] icache_req_addr,
    input  logic [63:0]     icache_data,
    input  logic            icache_data_valid,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_npc,
    output logic [15:0]     squash_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    fetch_packet_t   slot_q, slot_d;
    logic [15:0]     squash_count_q, squash_count_d;

    logic flush;
    logic bp_sel;
    logic deliver;
    logic slot_free;
    logic req_valid_int;
    logic req_fire;
    logic resp_load;
    logic resp_drop;

    // Handshake and request-side qualifiers; a request may go out while
    // the slot is being consumed so back-to-back delivery is possible.
    always_comb begin
        deliver       = slot_q.valid & ~fetch_stall;
        slot_free     = ~slot_q.valid | ~fetch_stall;
        req_valid_int = (state_q == FETCH) & slot_free;
        req_fire      = req_valid_int & icache_req_ready;
        resp_load     = (state_q == WAIT) & icache_data_valid & ~flush;
        resp_drop     = icache_data_valid &
                        (((state_q == WAIT) & flush) | (state_q == DRAIN));
    end

    fetch_redirect_mux u_redirect_mux (
        .ex_redirect_valid  (ex_redirect_valid),
        .ex_redirect_pc     (ex_redirect_pc),
        .rob_redirect_valid (rob_redirect_valid),
        .rob_redirect_pc    (rob_redirect_pc),
        .bp_take            (deliver & bp_redirect_valid),
        .bp_redirect_pc     (bp_redirect_pc),
        .seq_advance        (resp_load),
        .cur_pc             (pc_q),
        .flush              (flush),
        .bp_sel             (bp_sel),
        .next_pc            (pc_d)
    );

    // Next-state for the FSM, output slot and squash counter. A request
    // accepted while the PC is being redirected (flush or prediction) no
    // longer matches the PC, so its response must be drained.
    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        squash_count_d = squash_count_q;

        case (state_q)
            FETCH: begin
                if (req_fire) begin
                    state_d = (flush | bp_sel) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (icache_data_valid) begin
                    state_d = FETCH;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (icache_data_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (flush) begin
            slot_d.valid = 1'b0;
        end else if (resp_load) begin
            slot_d.valid = 1'b1;
            slot_d.inst  = pc_q[2] ? icache_data[63:32] : icache_data[31:0];
            slot_d.pc    = pc_q;
            slot_d.npc   = pc_q + 32'd4;
        end else if (deliver) begin
            slot_d.valid = 1'b0;
        end

        if (resp_drop && (squash_count_q != 16'hFFFF)) begin
            squash_count_d = squash_count_q + 16'd1;
        end
    end

    // All sequential state, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= FETCH;
            pc_q           <= word_align(RESET_PC);
            slot_q         <= '0;
            squash_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            slot_q         <= slot_d;
            squash_count_q <= squash_count_d;
        end
    end

    // Request valid is forced low while reset is held.
    assign icache_req_valid = req_valid_int & reset_n;
    assign icache_req_addr  = line_align(pc_q);
    assign inst_valid       = slot_q.valid;
    assign inst             = slot_q.inst;
    assign inst_pc          = slot_q.pc;
    assign inst_npc         = slot_q.npc;
    assign squash_count     = squash_count_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: latency-2 I-cache model, delivery scoreboard,
// and one task per scenario.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] MAGIC = 32'h0BAD_0000;

    logic        clock;
    logic        reset_n;
    logic        ex_redirect_valid;
    logic [31:0] ex_redirect_pc;
    logic        rob_redirect_valid;
    logic [31:0] rob_redirect_pc;
    logic        bp_redirect_valid;
    logic [31:0] bp_redirect_pc;
    logic        fetch_stall;
    logic        icache_req_ready;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic [63:0] icache_data;
    logic        icache_data_valid;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_npc;
    logic [15:0] squash_count;

    int errors = 0;
    int checks = 0;
    int n_deliv = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_q[$];

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .ex_redirect_valid  (ex_redirect_valid),
        .ex_redirect_pc     (ex_redirect_pc),
        .rob_redirect_valid (rob_redirect_valid),
        .rob_redirect_pc    (rob_redirect_pc),
        .bp_redirect_valid  (bp_redirect_valid),
        .bp_redirect_pc     (bp_redirect_pc),
        .fetch_stall        (fetch_stall),
        .icache_req_ready   (icache_req_ready),
        .icache_req_valid   (icache_req_valid),
        .icache_req_addr    (icache_req_addr),
        .icache_data        (icache_data),
        .icache_data_valid  (icache_data_valid),
        .inst_valid         (inst_valid),
        .inst               (inst),
        .inst_pc            (inst_pc),
        .inst_npc           (inst_npc),
        .squash_count       (squash_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every word in memory is its own address xor MAGIC.
    function automatic logic [63:0] mem_line(input logic [31:0] a);
        return {(a + 32'd4) ^ MAGIC, a ^ MAGIC};
    endfunction

    // I-cache model: responses driven at the falling edge, two cycles
    // after the request is accepted; requests sampled mid low phase.
    initial begin
        pend_t p;
        icache_data_valid = 1'b0;
        icache_data       = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                icache_data_valid = 1'b1;
                icache_data       = mem_line(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                icache_data_valid = 1'b0;
                icache_data       = '0;
            end
            #2;
            if (icache_req_valid && icache_req_ready) begin
                p.addr = icache_req_addr;
                p.due  = cyc + 2;
                pend_q.push_back(p);
                req_log.push_back(icache_req_addr);
                $display("[%0t] req  addr=%h", $time, icache_req_addr);
            end
        end
    end

    // Delivery scoreboard: each handshake pops the next expected pc.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            #3;
            if (reset_n && inst_valid && !fetch_stall) begin
                n_deliv++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL deliver_unexpected: got inst_pc=%h, required no delivery", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    $display("[%0t] dlv  pc=%h inst=%h npc=%h", $time, inst_pc, inst, inst_npc);
                    if (inst_pc !== e) begin
                        errors++;
                        $display("FAIL deliver_pc: got %h, required %h", inst_pc, e);
                    end
                    checks++;
                    if (inst !== (e ^ MAGIC)) begin
                        errors++;
                        $display("FAIL deliver_inst: got %h, required %h", inst, e ^ MAGIC);
                    end
                    checks++;
                    if (inst_npc !== e + 32'd4) begin
                        errors++;
                        $display("FAIL deliver_npc: got %h, required %h", inst_npc, e + 32'd4);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    // One delivery handshake in the current cycle, then stall again.
    task automatic consume(input logic [31:0] pc);
        exp_q.push_back(pc);
        fetch_stall = 1'b0;
        next_cycle();
        fetch_stall = 1'b1;
    endtask

    task automatic wait_slot(output bit ok);
        for (int i = 0; i < 30 && !inst_valid; i++) next_cycle();
        ok = inst_valid;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        ex_redirect_valid = 0; ex_redirect_pc = '0;
        rob_redirect_valid = 0; rob_redirect_pc = '0;
        bp_redirect_valid = 0; bp_redirect_pc = '0;
        fetch_stall = 1'b0;
        icache_req_ready = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) next_cycle();
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b, required 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h, required 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h, required 0", inst_pc); end
        checks++; if (inst_npc !== 32'h0) begin errors++; $display("FAIL reset_inst_npc: got %h, required 0", inst_npc); end
        checks++; if (squash_count !== 16'h0) begin errors++; $display("FAIL reset_squash: got %h, required 0", squash_count); end
        checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b, required 0", icache_req_valid); end
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 40 && n_deliv < 3; i++) next_cycle();
        fetch_stall = 1'b1;
        checks++; if (n_deliv != 3) begin errors++; $display("FAIL seq_timeout: got %0d deliveries, required 3", n_deliv); end
        checks++;
        if (req_log.size() < 3) begin
            errors++; $display("FAIL seq_req_count: got %0d, required >=3", req_log.size());
        end else if (req_log[0] !== 32'h0 || req_log[1] !== 32'h0 || req_log[2] !== 32'h8) begin
            errors++; $display("FAIL seq_req_addr: got %h %h %h, required 0 0 8", req_log[0], req_log[1], req_log[2]);
        end
    endtask

    task automatic test_stall();
        bit ok;
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_slot_timeout: got empty slot, required full"); end
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin errors++; $display("FAIL stall_hold: got v=%b pc=%h, required v=1 pc=0000000c", inst_valid, inst_pc); end
            checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req: got %b, required 0", icache_req_valid); end
            checks++; if (req_log.size() != 4) begin errors++; $display("FAIL stall_req_count: got %0d, required 4", req_log.size()); end
            next_cycle();
        end
        exp_q.push_back(32'hC);
        fetch_stall = 1'b0;
        #3;
        checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h10) begin errors++; $display("FAIL stall_release_req: got v=%b a=%h, required v=1 a=00000010", icache_req_valid, icache_req_addr); end
        next_cycle();
        fetch_stall = 1'b1;
    endtask

    task automatic test_flush_in_wait();
        bit ok;
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fw_slot_timeout: got empty slot, required full"); end
        consume(32'h10);
        ex_redirect_valid = 1'b1;  ex_redirect_pc = 32'h1111_1111;
        rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h2222_2222;
        next_cycle();
        ex_redirect_valid = 1'b0;
        rob_redirect_valid = 1'b0;
        #3;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fw_slot_cleared: got %b, required 0", inst_valid); end
        checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL fw_drain_no_req: got %b, required 0", icache_req_valid); end
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fw_refill_timeout: got empty slot, required full"); end
        checks++; if (squash_count !== 16'd1) begin errors++; $display("FAIL fw_squash: got %0d, required 1", squash_count); end
        checks++; if (req_log[req_log.size()-1] !== 32'h1111_1110) begin errors++; $display("FAIL fw_req_addr: got %h, required 11111110", req_log[req_log.size()-1]); end
        consume(32'h1111_1110);
    endtask

    task automatic test_bp_redirect();
        bit ok;
        int bad;
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_slot_timeout: got empty slot, required full"); end
        rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h0000_0100;
        next_cycle();
        rob_redirect_valid = 1'b0;
        #3;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_flush_slot: got %b, required 0", inst_valid); end
        checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h100) begin errors++; $display("FAIL fetch_flush_req: got v=%b a=%h, required v=1 a=00000100", icache_req_valid, icache_req_addr); end
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_slot2_timeout: got empty slot, required full"); end
        icache_req_ready = 1'b0;
        bp_redirect_valid = 1'b1; bp_redirect_pc = 32'h3333_3330;
        consume(32'h100);
        icache_req_ready = 1'b1;
        bp_redirect_pc = 32'h4444_4440;
        #3;
        checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h3333_3330) begin errors++; $display("FAIL bp_target_req: got v=%b a=%h, required v=1 a=33333330", icache_req_valid, icache_req_addr); end
        repeat (3) next_cycle();
        bp_redirect_valid = 1'b0;
        wait_slot(ok);
        consume(32'h3333_3330);
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_ignored_timeout: got empty slot, required full"); end
        consume(32'h3333_3334);
        bad = 0;
        foreach (req_log[i]) if (req_log[i] === 32'h4444_4440) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_ignored_req: got %0d requests to 44444440, required 0", bad); end
    endtask

    task automatic test_flush_with_response();
        bit ok;
        next_cycle();
        ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h5555_5550;
        next_cycle();
        ex_redirect_valid = 1'b0;
        #3;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fr_slot: got %b, required 0", inst_valid); end
        checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h5555_5550) begin errors++; $display("FAIL fr_req: got v=%b a=%h, required v=1 a=55555550", icache_req_valid, icache_req_addr); end
        checks++; if (squash_count !== 16'd2) begin errors++; $display("FAIL fr_squash: got %0d, required 2", squash_count); end
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fr_slot_timeout: got empty slot, required full"); end
        consume(32'h5555_5550);
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        reset_n = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_npc !== 32'h0) begin errors++; $display("FAIL rst_slot: got v=%b i=%h pc=%h npc=%h, required all 0", inst_valid, inst, inst_pc, inst_npc); end
        checks++; if (squash_count !== 16'h0) begin errors++; $display("FAIL rst_squash: got %0d, required 0", squash_count); end
        checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, required 0", icache_req_valid); end
        next_cycle();
        reset_n = 1'b1;
        #3;
        checks++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0) begin errors++; $display("FAIL rst_restart_req: got v=%b a=%h, required v=1 a=00000000", icache_req_valid, icache_req_addr); end
        wait_slot(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_slot_timeout: got empty slot, required full"); end
        checks++; if (squash_count !== 16'h0) begin errors++; $display("FAIL rst_late_resp: got squash %0d, required 0", squash_count); end
        consume(32'h0);
        repeat (4) next_cycle();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush_in_wait();
        test_bp_redirect();
        test_flush_with_response();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
